// File: rtl/blink_pkg.sv
// Shared types and constants for the blink frequency classifier.
// The optional BLINK_TRACK_EN macro is consumed by blink_freq_classifier.
`timescale 1ns/1ps
package blink_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Default period windows in clk cycles at 100 MHz (roughly +/-10 %)
  localparam int unsigned DEF_LO_200HZ  = 32'd450000;
  localparam int unsigned DEF_HI_200HZ  = 32'd550000;
  localparam int unsigned DEF_LO_1KHZ   = 32'd90000;
  localparam int unsigned DEF_HI_1KHZ   = 32'd110000;
  localparam int unsigned DEF_LO_5KHZ   = 32'd18000;
  localparam int unsigned DEF_HI_5KHZ   = 32'd22000;
  localparam int unsigned DEF_LO_6K9HZ  = 32'd13000;
  localparam int unsigned DEF_HI_6K9HZ  = 32'd15800;
  localparam int unsigned DEF_LO_10KHZ  = 32'd9000;
  localparam int unsigned DEF_HI_10KHZ  = 32'd11000;

  // True in the states where a measurement is in progress
  function automatic logic is_active(input state_t s);
    return (s == ST_ARM) || (s == ST_MEASURE);
  endfunction

endpackage

// File: rtl/blink_period_meter.sv
// Blink front end: 2-flop synchroniser, registered rising-edge detect,
// saturating period counter and stale-measurement flag.
`timescale 1ns/1ps
module blink_period_meter #(
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_clear,
  input  logic             i_blink,
  output logic             o_rise,
  output logic [CNT_W-1:0] o_count,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync2_d;
  logic             r_rise;
  logic [CNT_W-1:0] r_count;

  // Synchronise the asynchronous blink input and keep one delayed copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
    end else begin
      r_sync1   <= i_blink;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
    end
  end

  // Registered rising-edge pulse: blink_in rise to o_rise is 3 clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
    end else begin
      r_rise <= r_sync2 & ~r_sync2_d;
    end
  end

  // Period counter: clear wins, restarts at 1 on an edge, else saturating count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run) begin
      if (r_rise) begin
        r_count <= CNT_ONE;
      end else if (r_count != CNT_MAX) begin
        r_count <= r_count + CNT_ONE;
      end else begin
        r_count <= r_count;
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign o_rise    = r_rise;
  assign o_count   = r_count;
  assign o_timeout = (r_count >= CNT_TO);

endmodule

// File: rtl/blink_freq_classifier.sv
// Blink period classifier: measures the blink period, matches it against
// NUM_CLASS inclusive windows (lowest index wins) and declares a class after
// CONFIRM consecutive agreeing periods. Define BLINK_TRACK_EN to keep
// tracking in DONE instead of freezing the result.
`timescale 1ns/1ps
module blink_freq_classifier
  import blink_pkg::*;
#(
  parameter int NUM_CLASS = 5,
  parameter int CNT_W     = 20,
  parameter int CONFIRM   = 4,
  parameter int TIMEOUT   = 1000000,
  parameter int ANS_W     = $clog2(NUM_CLASS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       blink_in,
  input  logic [NUM_CLASS*CNT_W-1:0] lo_flat,
  input  logic [NUM_CLASS*CNT_W-1:0] hi_flat,
  output logic [ANS_W-1:0]           answer,
  output logic                       done,
  output logic                       busy,
  output logic [NUM_CLASS-1:0]       light_out
);

  localparam int IDX_W = $clog2(NUM_CLASS);
  localparam int AGR_W = $clog2(CONFIRM + 1);
  localparam logic [AGR_W-1:0]     AGR_FULL  = AGR_W'(CONFIRM);
  localparam logic [AGR_W-1:0]     AGR_ONE   = AGR_W'(1'b1);
  localparam logic [ANS_W-1:0]     ANS_ONE   = ANS_W'(1'b1);
  localparam logic [NUM_CLASS-1:0] LIGHT_ONE = NUM_CLASS'(1'b1);

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_cand, w_cand_nxt, w_cand_upd;
  logic                 r_cand_vld, w_cand_vld_nxt, w_cand_vld_upd;
  logic [AGR_W-1:0]     r_agree, w_agree_nxt, w_agree_upd;
  logic [ANS_W-1:0]     r_answer, w_answer_nxt;
  logic [NUM_CLASS-1:0] r_light, w_light_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_busy;

  logic                 w_run, w_clear, w_rise, w_timeout;
  logic [CNT_W-1:0]     w_period;
  logic [NUM_CLASS-1:0] w_match;
  logic                 w_hit, w_confirm;
  logic [IDX_W-1:0]     w_idx;
  logic [ANS_W-1:0]     w_new_ans;
  logic [NUM_CLASS-1:0] w_new_light;

`ifdef BLINK_TRACK_EN
  assign w_run = is_active(r_state) || (r_state == ST_DONE);
`else
  assign w_run = is_active(r_state);
`endif
  // start and a stale measurement both restart the period counter
  assign w_clear = start | (w_run & w_timeout);

  blink_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_meter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (w_run),
    .i_clear   (w_clear),
    .i_blink   (blink_in),
    .o_rise    (w_rise),
    .o_count   (w_period),
    .o_timeout (w_timeout)
  );

  // Inclusive window test for every class; lo > hi can never match
  always_comb begin
    w_match = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      w_match[k] = (w_period >= lo_flat[k*CNT_W +: CNT_W]) &&
                   (w_period <= hi_flat[k*CNT_W +: CNT_W]);
    end
  end

  // Priority pick of the lowest matching class index
  always_comb begin
    w_idx = '0;
    for (int k = NUM_CLASS - 1; k >= 0; k--) begin
      w_idx = w_match[k] ? IDX_W'(k) : w_idx;
    end
    w_hit       = |w_match;
    w_new_ans   = ANS_W'(w_idx) + ANS_ONE;
    w_new_light = LIGHT_ONE << w_idx;
  end

  // Candidate / agree bookkeeping for a measured period
  always_comb begin
    w_cand_upd     = r_cand;
    w_cand_vld_upd = r_cand_vld;
    w_agree_upd    = r_agree;
    if (!w_hit) begin
      w_cand_vld_upd = 1'b0;
      w_agree_upd    = '0;
    end else if (r_cand_vld && (w_idx == r_cand)) begin
      w_agree_upd = (r_agree == AGR_FULL) ? r_agree : (r_agree + AGR_ONE);
    end else begin
      w_cand_upd     = w_idx;
      w_cand_vld_upd = 1'b1;
      w_agree_upd    = AGR_ONE;
    end
    w_confirm = w_hit && (w_agree_upd == AGR_FULL);
  end

  // Next-state and next-output logic of the measurement FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_cand_nxt     = r_cand;
    w_cand_vld_nxt = r_cand_vld;
    w_agree_nxt    = r_agree;
    w_answer_nxt   = r_answer;
    w_light_nxt    = r_light;
    w_done_nxt     = r_done;
    if (start) begin
      w_state_nxt    = ST_ARM;
      w_cand_vld_nxt = 1'b0;
      w_agree_nxt    = '0;
      w_answer_nxt   = '0;
      w_light_nxt    = '0;
      w_done_nxt     = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_ARM: begin
          if (w_timeout) begin
            w_cand_vld_nxt = 1'b0;
            w_agree_nxt    = '0;
          end else if (w_rise) begin
            w_state_nxt = ST_MEASURE;
          end else begin
            w_state_nxt = ST_ARM;
          end
        end
        ST_MEASURE: begin
          if (w_timeout) begin
            w_state_nxt    = ST_ARM;
            w_cand_vld_nxt = 1'b0;
            w_agree_nxt    = '0;
          end else if (w_rise) begin
            w_cand_nxt     = w_cand_upd;
            w_cand_vld_nxt = w_cand_vld_upd;
            w_agree_nxt    = w_agree_upd;
            if (w_confirm) begin
              w_answer_nxt = w_new_ans;
              w_light_nxt  = w_new_light;
              w_done_nxt   = 1'b1;
              w_state_nxt  = ST_DONE;
            end else begin
              w_state_nxt = ST_MEASURE;
            end
          end else begin
            w_state_nxt = ST_MEASURE;
          end
        end
        ST_DONE: begin
`ifdef BLINK_TRACK_EN
          if (w_timeout) begin
            w_state_nxt    = ST_ARM;
            w_cand_vld_nxt = 1'b0;
            w_agree_nxt    = '0;
            w_answer_nxt   = '0;
            w_light_nxt    = '0;
            w_done_nxt     = 1'b0;
          end else if (w_rise) begin
            w_cand_nxt     = w_cand_upd;
            w_cand_vld_nxt = w_cand_vld_upd;
            w_agree_nxt    = w_agree_upd;
            if (w_confirm && (w_new_ans != r_answer)) begin
              w_answer_nxt = w_new_ans;
              w_light_nxt  = w_new_light;
            end else begin
              w_answer_nxt = r_answer;
            end
          end else begin
            w_state_nxt = ST_DONE;
          end
`else
          w_state_nxt = ST_DONE;
`endif
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cand     <= '0;
      r_cand_vld <= 1'b0;
      r_agree    <= '0;
      r_answer   <= '0;
      r_light    <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cand     <= w_cand_nxt;
      r_cand_vld <= w_cand_vld_nxt;
      r_agree    <= w_agree_nxt;
      r_answer   <= w_answer_nxt;
      r_light    <= w_light_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= is_active(w_state_nxt);
    end
  end

  assign answer    = r_answer;
  assign done      = r_done;
  assign busy      = r_busy;
  assign light_out = r_light;

endmodule

// File: doc/blink_freq_classifier.md
Name: blink_freq_classifier

Overview:
Parametrised successor to the single-purpose blink decision counter. It measures the period of an asynchronous blink input in clock cycles and classifies it against NUM_CLASS programmable period windows. It declares a result only after CONFIRM consecutive agreeing periods. It sits between the photodiode/blink front end and the LED/answer display logic, and adds start/restart control, timeout and a busy flag.

Parameters:
NUM_CLASS, 5, number of frequency classes (≥2)
CNT_W, 20, period counter width in bits; counter saturates at 2^CNT_W-1
CONFIRM, 4, consecutive matching periods required for a decision (≥1)
TIMEOUT, 1000000, cycles without a rising edge before the measurement is declared stale (< 2^CNT_W)
ANS_W, $clog2(NUM_CLASS+1), answer width (derived; do not override)

Ports:
clk  in  1  system clock (100 MHz nominal)
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins or restarts a measurement
blink_in  in  1  asynchronous blink signal
lo_flat  in  NUM_CLASS*CNT_W  per-class lower period bound, class k at bits [k*CNT_W +: CNT_W]
hi_flat  in  NUM_CLASS*CNT_W  per-class upper period bound, same packing
answer  out  ANS_W  0 = no decision; k+1 = class k decided
done  out  1  high while answer is valid
busy  out  1  high in ARM or MEASURE
light_out  out  NUM_CLASS  one-hot of decided class; all-zero when no decision

Behaviour:
- Reset: clk and rst_n are fixed as one clock with asynchronous active-low reset. All outputs reset to 0. The FSM resets to IDLE. Sync flops, counter, candidate and agree count are cleared.
- Input handling: blink_in passes through a 2-flop synchroniser, then a registered rising-edge detect (rise). Latency from a blink_in rise to the rise pulse is 3 clk.
- Period counter: increments every cycle in ARM/MEASURE, saturates, and clears to 1 on rise.
- FSM states: IDLE, ARM, MEASURE, DONE.
  - IDLE: waits for start, then goes to ARM.
  - ARM: first rise clears the counter and moves to MEASURE. No classification in ARM.
  - MEASURE: on each rise, period = counter value. class = lowest k with lo_k ≤ period ≤ hi_k (inclusive). No match = unknown.
    - Unknown: agree count cleared, candidate invalid.
    - Match equal to candidate: agree increments. Otherwise candidate = k and agree = 1.
    - When agree reaches CONFIRM: answer = k+1, light_out = 1<<k, done = 1, go to DONE. Outputs update on the clock after the deciding rise.
  - DONE: outputs hold; busy = 0.
- Timeout: in ARM or MEASURE, counter ≥ TIMEOUT clears candidate and agree and returns to ARM. Outputs are not changed.
- start in any state: clears done, answer, light_out, candidate and agree, then goes to ARM on the next cycle. start has priority over a simultaneous rise.
- Overlapping windows: the lowest index wins. A window with lo > hi never matches.
- With CONFIRM = 1, the decision is made on the first measured period.
- Async reset mid-measurement returns to IDLE immediately; no output glitch beyond the reset clear.

Optional Feature:
BLINK_TRACK_EN.
- Defined: DONE keeps measuring. A newly confirmed different class (CONFIRM agreeing periods) updates answer/light_out in place and done stays high. Timeout in DONE clears answer, light_out and done, then goes to ARM.
- Undefined: DONE freezes as described above. start is the only way out.

Decomposition:
- Package blink_pkg holds the FSM state enum (IDLE/ARM/MEASURE/DONE) and default period window constants for 200 Hz, 1 kHz, 5 kHz, 6.9 kHz and 10 kHz at 100 MHz.
- One natural sub-module: blink_period_meter (synchroniser, edge detect, saturating counter, timeout flag). Classification and FSM stay in the top.

Test Plan:
Window settings for the first four scenarios: class0 [450000,550000], class1 [90000,110000], class2 [18000,22000], class3 [13000,15800], class4 [9000,11000]; CONFIRM = 4.
1. start, then blink_in half-period 2.5 ms (period 500000 clk) -> done=1 and answer=1, light_out=5'b00001, both after the 5th rising edge (+≤4 clk). busy=0 after.
2. start, then 3 periods at 1 kHz followed by 72 µs half-periods (14400 clk) -> answer=4, light_out=5'b01000 after 4 consecutive 14400-cycle periods. 1 kHz never decided.
3. start, then blink stops low for > TIMEOUT -> FSM back in ARM, done=0, answer=0, busy=1. Resuming at 5 kHz -> answer=3.
4. start asserted mid-MEASURE on the same cycle as rise -> agree cleared, state ARM, no decision from the pre-start edges.
5. Reset and overlap checks:
   - rst_n low during MEASURE -> all outputs 0 immediately, state IDLE.
   - Overlapping windows class1 = class2 = [18000,22000] with a 5 kHz input -> answer=2 (lowest index).
6. BLINK_TRACK_EN defined: decided at 1 kHz (answer=2), input switches to 5 kHz -> answer=3 after 4 periods with done held high. Macro undefined -> answer stays 2.
